// File: rtl/xbus_link_if.sv
// XBus endpoint-pair signal bundle: request/data from each side and the
// registered peer acknowledge/valid/data returned to each side.
interface xbus_link_if #(
    parameter int unsigned DATA_W = 11
);
    logic              a_write_req;
    logic [DATA_W-1:0] a_wdata;
    logic              a_read_req;
    logic              a_peer_read;
    logic              a_peer_write;
    logic [DATA_W-1:0] a_peer_dat;

    logic              b_write_req;
    logic [DATA_W-1:0] b_wdata;
    logic              b_read_req;
    logic              b_peer_read;
    logic              b_peer_write;
    logic [DATA_W-1:0] b_peer_dat;

    modport master (
        output a_write_req, a_wdata, a_read_req,
        output b_write_req, b_wdata, b_read_req,
        input  a_peer_read, a_peer_write, a_peer_dat,
        input  b_peer_read, b_peer_write, b_peer_dat
    );

    modport slave (
        input  a_write_req, a_wdata, a_read_req,
        input  b_write_req, b_wdata, b_read_req,
        output a_peer_read, a_peer_write, a_peer_dat,
        output b_peer_read, b_peer_write, b_peer_dat
    );
endinterface

// File: rtl/xbus_link.sv
// Point-to-point XBus rendezvous link: one-word buffer, alternating-priority arbiter.
// Optional stall watchdog enabled by defining XBUS_DEADLOCK_EN.
module xbus_link #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned CNT_W  = 16
`ifdef XBUS_DEADLOCK_EN
    ,
    parameter int unsigned DEADLOCK_CYCLES = 64
`endif
) (
    input  logic             clk,
    input  logic             reset,
    xbus_link_if.slave       bus,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count,
    output logic             deadlock
);

    typedef enum logic [2:0] {StIdle, StHoldA, StHoldB, StAckA, StAckB} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              prio_b_q, prio_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              a_pr_q, a_pr_d, a_pw_q, a_pw_d;
    logic              b_pr_q, b_pr_d, b_pw_q, b_pw_d;
    logic [DATA_W-1:0] a_pd_q, a_pd_d, b_pd_q, b_pd_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        prio_b_d = prio_b_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                // On a tie, prio_b_q set means A completed last, so B goes first.
                if (bus.a_write_req && (!bus.b_write_req || !prio_b_q)) begin
                    state_d = StHoldA;
                    buf_d   = bus.a_wdata;
                end else if (bus.b_write_req) begin
                    state_d = StHoldB;
                    buf_d   = bus.b_wdata;
                end
            end
            StHoldA: begin
                if (!bus.a_write_req) begin
                    state_d = StIdle;
                end else if (bus.b_read_req) begin
                    state_d = StAckA;
                end
            end
            StHoldB: begin
                if (!bus.b_write_req) begin
                    state_d = StIdle;
                end else if (bus.a_read_req) begin
                    state_d = StAckB;
                end
            end
            StAckA: begin
                if (!bus.a_write_req) begin
                    state_d  = StIdle;
                    prio_b_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            StAckB: begin
                if (!bus.b_write_req) begin
                    state_d  = StIdle;
                    prio_b_d = 1'b0;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the current state into registers, so peers see it one edge later.
    always_comb begin
        a_pr_d = (state_q == StAckA);
        b_pr_d = (state_q == StAckB);
        a_pw_d = (state_q == StHoldB);
        b_pw_d = (state_q == StHoldA);
        a_pd_d = (state_q == StHoldB) ? buf_q : '0;
        b_pd_d = (state_q == StHoldA) ? buf_q : '0;
        busy_d = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            buf_q    <= '0;
            prio_b_q <= 1'b0;
            cnt_q    <= '0;
            a_pr_q   <= 1'b0;
            a_pw_q   <= 1'b0;
            a_pd_q   <= '0;
            b_pr_q   <= 1'b0;
            b_pw_q   <= 1'b0;
            b_pd_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            prio_b_q <= prio_b_d;
            cnt_q    <= cnt_d;
            a_pr_q   <= a_pr_d;
            a_pw_q   <= a_pw_d;
            a_pd_q   <= a_pd_d;
            b_pr_q   <= b_pr_d;
            b_pw_q   <= b_pw_d;
            b_pd_q   <= b_pd_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.a_peer_read  = a_pr_q;
    assign bus.a_peer_write = a_pw_q;
    assign bus.a_peer_dat   = a_pd_q;
    assign bus.b_peer_read  = b_pr_q;
    assign bus.b_peer_write = b_pw_q;
    assign bus.b_peer_dat   = b_pd_q;
    assign busy             = busy_q;
    assign xfer_count       = cnt_q;

`ifdef XBUS_DEADLOCK_EN
    localparam int unsigned DlW = $clog2(DEADLOCK_CYCLES + 1);

    logic [DlW-1:0] dl_cnt_q, dl_cnt_d;
    logic           dl_q, dl_d;
    logic           stall;

    always_comb begin
        stall = ((state_q == StHoldA) && bus.b_write_req && !bus.b_read_req) ||
                ((state_q == StHoldB) && bus.a_write_req && !bus.a_read_req) ||
                ((state_q == StIdle) && bus.a_read_req && bus.b_read_req &&
                 !bus.a_write_req && !bus.b_write_req);
        dl_cnt_d = '0;
        if (stall) begin
            dl_cnt_d = (dl_cnt_q == DlW'(DEADLOCK_CYCLES)) ? dl_cnt_q : dl_cnt_q + DlW'(1);
        end
        dl_d = dl_q | (dl_cnt_d == DlW'(DEADLOCK_CYCLES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_cnt_q <= '0;
            dl_q     <= 1'b0;
        end else begin
            dl_cnt_q <= dl_cnt_d;
            dl_q     <= dl_d;
        end
    end

    assign deadlock = dl_q;
`else
    assign deadlock = 1'b0;
`endif

endmodule
